// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue
// In-order queue of predicted branches awaiting resolution by execute.
// Fetch pushes one prediction per cycle, and execute resolves the oldest one.
// Every accepted resolution sends one training pulse to the global predictor.
// A mispredict also raises a one-cycle flush/redirect to the front end,
// empties the queue, and spends one FLUSH cycle refusing new work.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alloc_valid/ready             push handshake (ready is combinational)
//   alloc_pc/pred_taken/target/bhr  predicted branch record
//   res_valid/taken/target        resolution of the head entry
//   upd_valid/pc/taken/bhr        registered predictor training pulse
//   flush, redirect_pc            registered mispredict pulse and correct PC
//   empty, count                  occupancy
//   branch_cnt, mispredict_cnt    saturating statistics
module branch_resolution_queue #(
  parameter int DEPTH     = 4,
  parameter int BHR_WIDTH = 4,
  parameter int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [31:0]          alloc_pc,
  input  logic                 alloc_pred_taken,
  input  logic [31:0]          alloc_target,
  input  logic [BHR_WIDTH-1:0] alloc_bhr,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  output logic                 upd_valid,
  output logic [31:0]          upd_pc,
  output logic                 upd_taken,
  output logic [BHR_WIDTH-1:0] upd_bhr,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic                 empty,
  output logic [CW-1:0]        count,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispredict_cnt
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  // Entry storage; the head is read combinationally so it can be compared
  // against the resolution in the same cycle.
  logic [31:0]          pc_mem     [DEPTH];
  logic                 pt_mem     [DEPTH];
  logic [31:0]          tgt_mem    [DEPTH];
  logic [BHR_WIDTH-1:0] bhr_mem    [DEPTH];

  state_t               state_q, state_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [31:0]          upd_pc_q, upd_pc_d;
  logic                 upd_taken_q, upd_taken_d;
  logic [BHR_WIDTH-1:0] upd_bhr_q, upd_bhr_d;
  logic                 flush_q, flush_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic [31:0]          branch_cnt_q, branch_cnt_d;
  logic [31:0]          mispredict_cnt_q, mispredict_cnt_d;

  logic push, res_acc, mispred;

  assign alloc_ready = (state_q == RUN) && (count_q < CW'(DEPTH));
  assign push        = alloc_valid && alloc_ready;
  assign res_acc     = (state_q == RUN) && res_valid && (count_q != '0);
  // A taken resolution must also match the predicted target.
  assign mispred     = (res_taken != pt_mem[rd_ptr_q]) ||
                       (res_taken && (res_target != tgt_mem[rd_ptr_q]));

  always_comb begin
    state_d          = RUN;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    upd_valid_d      = res_acc;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    upd_bhr_d        = upd_bhr_q;
    flush_d          = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    if (res_acc) begin
      upd_pc_d    = pc_mem[rd_ptr_q];
      upd_taken_d = res_taken;
      upd_bhr_d   = bhr_mem[rd_ptr_q];
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 32'd1;
    end

    if (res_acc && mispred) begin
      // Everything younger than the head is on the wrong path, including
      // a push arriving this cycle.
      state_d       = FLUSH;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
      flush_d       = 1'b1;
      redirect_pc_d = res_target;
      if (mispredict_cnt_q != '1) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end else begin
      // FLUSH lasts one cycle; push and res_acc are already blocked there.
      if (push)    wr_ptr_d = wr_ptr_q + PW'(1);
      if (res_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(res_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_bhr_q        <= '0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      upd_bhr_q        <= upd_bhr_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Entries need no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= alloc_pc;
      pt_mem[wr_ptr_q]  <= alloc_pred_taken;
      tgt_mem[wr_ptr_q] <= alloc_target;
      bhr_mem[wr_ptr_q] <= alloc_bhr;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_bhr        = upd_bhr_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign empty          = (count_q == '0);
  assign count          = count_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Testbench for branch_resolution_queue (DEPTH=4, BHR_WIDTH=4).
// Table vectors carry the hand-derived ready/count/flush expectations.
// A queue model predicts the training pulses into a scoreboard.
module tb_branch_resolution_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, alloc_pred_taken;
  logic [31:0] alloc_pc, alloc_target;
  logic [3:0]  alloc_bhr;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        upd_valid, upd_taken, flush, empty;
  logic [31:0] upd_pc, redirect_pc, branch_cnt, mispredict_cnt;
  logic [3:0]  upd_bhr;
  logic [2:0]  count;

  branch_resolution_queue #(.DEPTH(4), .BHR_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken),
    .alloc_target(alloc_target), .alloc_bhr(alloc_bhr),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_bhr(upd_bhr), .flush(flush), .redirect_pc(redirect_pc),
    .empty(empty), .count(count),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic [3:0]  bhr;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        exp_ready;
    logic [2:0]  exp_count;
    logic        exp_flush;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic [3:0]  bhr;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [3:0]  bhr;
  } upd_t;

  vec_t        vecs[28];
  ent_t        m_q[$];
  upd_t        sb_q[$];
  logic        m_flush;
  logic [31:0] m_redirect;
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(logic av, logic [31:0] pc, logic pt, logic [31:0] tgt,
                              logic [3:0] bhr, logic rv, logic rt, logic [31:0] rtgt,
                              logic er, logic [2:0] ec, logic ef);
    vec_t v;
    v.av = av; v.pc = pc; v.pt = pt; v.tgt = tgt; v.bhr = bhr;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt;
    v.exp_ready = er; v.exp_count = ec; v.exp_flush = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare the training pulse of the cycle just clocked against the scoreboard.
  task automatic check_upd();
    upd_t e;
    if (upd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("upd_unexpected", 32'(upd_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("upd_pc", upd_pc, e.pc);
        chk("upd_taken", 32'(upd_taken), 32'(e.taken));
        chk("upd_bhr", 32'(upd_bhr), 32'(e.bhr));
      end
    end else if (sb_q.size() != 0) begin
      chk("upd_missing", 32'(upd_valid), 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_pc = 0; alloc_pred_taken = 0; alloc_target = 0; alloc_bhr = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    ent_t e;
    upd_t u;
    logic ready_m, acc, mis, flush_next;
    alloc_valid = v.av; alloc_pc = v.pc; alloc_pred_taken = v.pt;
    alloc_target = v.tgt; alloc_bhr = v.bhr;
    res_valid = v.rv; res_taken = v.rt; res_target = v.rtgt;
    chk("alloc_ready", 32'(alloc_ready), 32'(v.exp_ready));

    // Reference model of one cycle.
    ready_m    = !m_flush && (m_q.size() < 4);
    acc        = !m_flush && v.rv && (m_q.size() > 0);
    flush_next = 1'b0;
    if (acc) begin
      e = m_q[0];
      mis = (v.rt != e.pt) || (v.rt && (v.rtgt != e.tgt));
      u.pc = e.pc; u.taken = v.rt; u.bhr = e.bhr;
      sb_q.push_back(u);
      if (mis) begin
        m_q.delete();
        flush_next = 1'b1;
        m_redirect = v.rtgt;
      end else begin
        void'(m_q.pop_front());
      end
    end
    if (ready_m && v.av && !flush_next) begin
      e.pc = v.pc; e.pt = v.pt; e.tgt = v.tgt; e.bhr = v.bhr;
      m_q.push_back(e);
    end

    @(posedge clk); #1;
    m_flush = flush_next;
    chk("count", 32'(count), 32'(v.exp_count));
    chk("flush", 32'(flush), 32'(v.exp_flush));
    chk("empty", 32'(empty), 32'(v.exp_count == 0));
    if (v.exp_flush) chk("redirect_pc", redirect_pc, m_redirect);
    check_upd();
    $display("vec %0d: av=%0b pc=%h rv=%0b rt=%0b rtgt=%h -> count=%0d flush=%0b redirect=%h upd_valid=%0b upd_pc=%h",
             idx, v.av, v.pc, v.rv, v.rt, v.rtgt, count, flush, redirect_pc, upd_valid, upd_pc);
  endtask

  task automatic model_reset();
    m_q.delete();
    sb_q.delete();
    m_flush = 1'b0;
    m_redirect = 32'd0;
  endtask

  initial begin
    // Fill to DEPTH, then one refused push.
    vecs[0]  = mk(1, 32'h100, 0, 32'h104, 4'd1, 0, 0, 0, 1, 3'd1, 0);
    vecs[1]  = mk(1, 32'h104, 0, 32'h108, 4'd2, 0, 0, 0, 1, 3'd2, 0);
    vecs[2]  = mk(1, 32'h108, 0, 32'h10C, 4'd3, 0, 0, 0, 1, 3'd3, 0);
    vecs[3]  = mk(1, 32'h10C, 0, 32'h110, 4'd4, 0, 0, 0, 1, 3'd4, 0);
    vecs[4]  = mk(1, 32'h110, 0, 32'h114, 4'd5, 0, 0, 0, 0, 3'd4, 0);
    // In-order correct not-taken resolves.
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd3, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 3'd2, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 3'd1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 3'd0, 0);
    // Resolve while empty: ignored.
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 3'd0, 0);
    // Direction mispredict, then the FLUSH cycle refuses a push and a resolve.
    vecs[10] = mk(1, 32'h120, 0, 32'h124, 4'd5, 0, 0, 0, 1, 3'd1, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 1, 32'h200, 1, 3'd0, 1);
    vecs[12] = mk(1, 32'h130, 0, 32'h134, 4'd6, 1, 1, 32'h999, 0, 3'd0, 0);
    // Target mispredict with a same-cycle push that must be discarded.
    vecs[13] = mk(1, 32'h140, 1, 32'h300, 4'd7, 0, 0, 0, 1, 3'd1, 0);
    vecs[14] = mk(1, 32'h150, 0, 32'h154, 4'd8, 1, 1, 32'h304, 1, 3'd0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    // Fill to 3, six push+resolve pairs across the pointer wrap, then drain.
    for (int i = 0; i < 3; i++)
      vecs[16+i] = mk(1, 32'h160 + 32'(4*i), 1, 32'h500, 4'(i), 0, 0, 0, 1, 3'(i+1), 0);
    for (int k = 0; k < 6; k++)
      vecs[19+k] = mk(1, 32'h16C + 32'(4*k), 1, 32'h500, 4'(k+3), 1, 1, 32'h500, 1, 3'd3, 0);
    for (int d = 0; d < 3; d++)
      vecs[25+d] = mk(0, 0, 0, 0, 0, 1, 1, 32'h500, 1, 3'(2-d), 0);

    idle();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_upd_pc", upd_pc, 32'd0);
    chk("rst_upd_taken", 32'(upd_taken), 32'd0);
    chk("rst_upd_bhr", 32'(upd_bhr), 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispredict_cnt", mispredict_cnt, 32'd0);
    rst = 0;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);

    for (int i = 0; i < 28; i++) begin
      apply(i, vecs[i]);
      if (i == 8)  chk("branch_cnt_after_drain", branch_cnt, 32'd4);
      if (i == 9)  chk("branch_cnt_empty_res", branch_cnt, 32'd4);
      if (i == 11) chk("mispredict_cnt_dir", mispredict_cnt, 32'd1);
    end
    chk("branch_cnt_total", branch_cnt, 32'd15);
    chk("mispredict_cnt_total", mispredict_cnt, 32'd2);

    // Reset during FLUSH.
    apply(100, mk(1, 32'h700, 0, 32'h704, 4'd9, 0, 0, 0, 1, 3'd1, 0));
    apply(101, mk(0, 0, 0, 0, 0, 1, 1, 32'h710, 1, 3'd0, 1));
    idle();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    chk("rstflush_flush", 32'(flush), 32'd0);
    chk("rstflush_count", 32'(count), 32'd0);
    chk("rstflush_upd_valid", 32'(upd_valid), 32'd0);
    chk("rstflush_ready", 32'(alloc_ready), 32'd1);
    chk("rstflush_branch_cnt", branch_cnt, 32'd0);
    $display("rst during flush: flush=%0b count=%0d alloc_ready=%0b", flush, count, alloc_ready);
    rst = 0;

    // Reset arriving together with a resolution suppresses its pulse.
    apply(102, mk(1, 32'h720, 0, 32'h724, 4'd3, 0, 0, 0, 1, 3'd1, 0));
    res_valid = 1; res_taken = 1; res_target = 32'h800;
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    chk("rstres_upd_valid", 32'(upd_valid), 32'd0);
    chk("rstres_flush", 32'(flush), 32'd0);
    chk("rstres_count", 32'(count), 32'd0);
    chk("rstres_mispredict_cnt", mispredict_cnt, 32'd0);
    idle();
    rst = 0;
    @(posedge clk); #1;
    chk("rstres_upd_after", 32'(upd_valid), 32'd0);
    chk("rstres_flush_after", 32'(flush), 32'd0);
    $display("rst with pending resolve: upd_valid=%0b flush=%0b count=%0d", upd_valid, flush, count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolution_queue.md
BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, in-flight branch entries (power of 2, >=2); BHR_WIDTH, default 4, history snapshot width; CW = $clog2(DEPTH)+1.
REQ-002 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-003 rst  in  1  reset; rst SHALL be synchronous and active-high.
REQ-004 alloc_valid  in  1  fetch pushes one predicted branch.
REQ-005 alloc_ready  out  1  queue accepts a push this cycle.
REQ-006 alloc_pc  in  32  branch PC.
REQ-007 alloc_pred_taken  in  1  predicted direction.
REQ-008 alloc_target  in  32  predicted next PC.
REQ-009 alloc_bhr  in  BHR_WIDTH  history snapshot used for the prediction.
REQ-010 res_valid  in  1  execute resolves the oldest in-flight branch.
REQ-011 res_taken  in  1  actual direction.
REQ-012 res_target  in  32  actual next PC.
REQ-013 upd_valid  out  1  one-cycle training pulse to the global predictor (drives its load).
REQ-014 upd_pc / upd_taken / upd_bhr  out  32/1/BHR_WIDTH  training PC, actual direction, prediction-time history.
REQ-015 flush  out  1  one-cycle mispredict pulse to the front end.
REQ-016 redirect_pc  out  32  correct next PC, valid when flush=1.
REQ-017 empty  out  1  no entries; count  out  CW  occupancy.
REQ-018 branch_cnt / mispredict_cnt  out  32/32  resolved and mispredicted branch totals.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries {pc, pred_taken, target, bhr}, rd/wr pointers wrapping DEPTH-1 -> 0.
REQ-020 FSM SHALL have states RUN and FLUSH; reset state RUN.
REQ-021 alloc_ready SHALL be combinational: 1 iff state==RUN and count<DEPTH; push occurs iff alloc_valid && alloc_ready.
REQ-022 In RUN, res_valid with count>0 SHALL pop the head entry; res_valid with count==0 SHALL be ignored (no pop, no pulses, no counter change).
REQ-023 Mispredict SHALL be: res_taken != head.pred_taken, or res_taken==1 && res_target != head.target.
REQ-024 Every accepted resolution SHALL produce, one cycle later, upd_valid=1 with upd_pc=head.pc, upd_taken=res_taken, upd_bhr=head.bhr; upd_* SHALL hold value otherwise, upd_valid=0.
REQ-025 On a correct resolution: pop only; a same-cycle push SHALL also occur, count unchanged.
REQ-026 On a mispredict: next cycle flush=1, redirect_pc=res_target, count=0, pointers reset to 0, state -> FLUSH; any same-cycle push SHALL be discarded.
REQ-027 FLUSH SHALL last exactly one cycle: alloc_ready=0, res_valid ignored, then -> RUN.
REQ-028 flush and upd_valid SHALL be single-cycle registered pulses; latency resolve->pulse = 1 cycle.
REQ-029 branch_cnt SHALL +1 per accepted resolution; mispredict_cnt SHALL +1 per mispredict; both saturate at 32'hFFFF_FFFF.
REQ-030 Push at count==DEPTH cannot occur (alloc_ready=0); pop at count==0 cannot occur (REQ-022); wrap-around SHALL preserve FIFO order.

Reset
REQ-031 On rst=1: count=0, empty=1, pointers=0, state RUN, upd_valid=0, flush=0, redirect_pc=0, upd_pc=0, upd_taken=0, upd_bhr=0, branch_cnt=0, mispredict_cnt=0; alloc_ready=1 in the first cycle after rst deasserts.
REQ-032 rst asserted mid-operation (including during FLUSH or with a resolution pending) SHALL discard all entries and suppress the pending upd_valid/flush pulse.

Verification
REQ-033 Fill: 4 pushes, pc=0x100,0x104,0x108,0x10C -> count=4, alloc_ready=0, 5th push not accepted, empty=0.
REQ-034 In-order resolve: 4 correct resolves -> upd_pc 0x100..0x10C in order, one cycle after each resolve, flush never 1, branch_cnt=4, empty=1.
REQ-035 Direction mispredict: head pred_taken=0, res_taken=1, res_target=0x200 -> next cycle flush=1, redirect_pc=0x200, upd_taken=1, count=0, alloc_ready=0 one cycle, mispredict_cnt=1.
REQ-036 Target mispredict: pred_taken=1, target=0x300, res_taken=1, res_target=0x304 -> flush=1, redirect_pc=0x304; same-cycle push discarded (count=0 after).
REQ-037 Wrap + simultaneous push/pop: 6 push/resolve pairs at count=3 -> count stays 3, upd_pc order matches push order across pointer wrap.
REQ-038 Edge: res_valid at empty -> no upd_valid, branch_cnt unchanged; rst during FLUSH -> flush=0, count=0, state RUN next cycle.
